// File: rtl/ex_mem_cond_stage.sv
// EX/MEM boundary stage: NZCV flags register, ARM condition evaluation and
// condition-gated EX/MEM pipeline register. `define SQUASH_CNT_EN adds squash_cnt.
module ex_mem_cond_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic [3:0]        cond_e,
    input  logic [1:0]        flag_write_e,
    input  logic [3:0]        alu_flags_e,
    input  logic [DATA_W-1:0] alu_result_e,
    input  logic [DATA_W-1:0] write_data_e,
    input  logic [REG_W-1:0]  rd_e,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic              mem_to_reg_e,
    input  logic              pc_src_e,
    output logic              cond_ex_e,
    output logic [3:0]        flags_q,
    output logic [DATA_W-1:0] alu_result_m,
    output logic [DATA_W-1:0] write_data_m,
    output logic [REG_W-1:0]  rd_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic              mem_to_reg_m,
    output logic              pc_src_m
`ifdef SQUASH_CNT_EN
    ,
    output logic [15:0]       squash_cnt
`endif
);

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned SQ_W   = 16;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_t;

    logic [FLAG_W-1:0] flags_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              pc_src_q, pc_src_d;

    logic  flag_n, flag_z, flag_c, flag_v;
    logic  cond_pass;
    logic  normal_adv;
    cond_t cond;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
    assign cond       = cond_t'(cond_e);
    assign normal_adv = !stall_e && !flush_e;

    // Condition evaluated against committed flags only; alu_flags_e is never bypassed.
    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = !flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = !flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = !flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = !flag_v;
            COND_HI: cond_pass = flag_c && !flag_z;
            COND_LS: cond_pass = !flag_c || flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = !flag_z && (flag_n == flag_v);
            COND_LE: cond_pass = flag_z || (flag_n != flag_v);
            default: cond_pass = 1'b1;
        endcase
    end

    assign cond_ex_e = cond_pass;

    // Next-state: stall holds everything, flush bubbles controls, normal loads gated values.
    always_comb begin
        flags_d      = flags_q;
        alu_result_d = alu_result_q;
        write_data_d = write_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        pc_src_d     = pc_src_q;

        if (!stall_e) begin
            alu_result_d = alu_result_e;
            write_data_d = write_data_e;
            rd_d         = rd_e;
            if (flush_e) begin
                reg_write_d  = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                pc_src_d     = 1'b0;
            end else begin
                reg_write_d  = reg_write_e && cond_pass;
                mem_write_d  = mem_write_e && cond_pass;
                mem_to_reg_d = mem_to_reg_e;
                pc_src_d     = pc_src_e && cond_pass;
                if (cond_pass) begin
                    if (flag_write_e[1]) flags_d[3:2] = alu_flags_e[3:2];
                    if (flag_write_e[0]) flags_d[1:0] = alu_flags_e[1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_src_q     <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_src_q     <= pc_src_d;
        end
    end

    assign alu_result_m = alu_result_q;
    assign write_data_m = write_data_q;
    assign rd_m         = rd_q;
    assign reg_write_m  = reg_write_q;
    assign mem_write_m  = mem_write_q;
    assign mem_to_reg_m = mem_to_reg_q;
    assign pc_src_m     = pc_src_q;

`ifdef SQUASH_CNT_EN
    logic [SQ_W-1:0] squash_q, squash_d;
    logic            squash_evt;

    // Counts squashed instructions that carried a side effect; saturating.
    assign squash_evt = normal_adv && !cond_pass && (reg_write_e || mem_write_e || pc_src_e);

    always_comb begin
        squash_d = squash_q;
        if (squash_evt && (squash_q != {SQ_W{1'b1}})) begin
            squash_d = squash_q + SQ_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_q <= '0;
        end else begin
            squash_q <= squash_d;
        end
    end

    assign squash_cnt = squash_q;
`else
    logic unused_normal_adv;
    assign unused_normal_adv = normal_adv;
`endif

endmodule

// File: tb/tb_ex_mem_cond_stage.sv
// Directed-vector bench for ex_mem_cond_stage; hand-computed expectations.
`timescale 1ns/1ps
module tb_ex_mem_cond_stage;

    logic        clk;
    logic        reset;
    logic        stall_e, flush_e;
    logic [3:0]  cond_e;
    logic [1:0]  flag_write_e;
    logic [3:0]  alu_flags_e;
    logic [31:0] alu_result_e, write_data_e;
    logic [3:0]  rd_e;
    logic        reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e;
    logic        cond_ex_e;
    logic [3:0]  flags_q;
    logic [31:0] alu_result_m, write_data_m;
    logic [3:0]  rd_m;
    logic        reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m;
`ifdef SQUASH_CNT_EN
    logic [15:0] squash_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    ex_mem_cond_stage #(.DATA_W(32), .REG_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .cond_e       (cond_e),
        .flag_write_e (flag_write_e),
        .alu_flags_e  (alu_flags_e),
        .alu_result_e (alu_result_e),
        .write_data_e (write_data_e),
        .rd_e         (rd_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .mem_to_reg_e (mem_to_reg_e),
        .pc_src_e     (pc_src_e),
        .cond_ex_e    (cond_ex_e),
        .flags_q      (flags_q),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .mem_to_reg_m (mem_to_reg_m),
        .pc_src_m     (pc_src_m)
`ifdef SQUASH_CNT_EN
        ,
        .squash_cnt   (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        stall_e = 1'b0; flush_e = 1'b0; cond_e = 4'hE; flag_write_e = 2'b00;
        alu_flags_e = 4'h0; alu_result_e = 32'h0; write_data_e = 32'h0; rd_e = 4'h0;
        reg_write_e = 1'b0; mem_write_e = 1'b0; mem_to_reg_e = 1'b0; pc_src_e = 1'b0;
    endtask

    // Walk all 16 condition codes against the current flags; bit i = pass for cond i.
    task automatic sweep(input string tag, input logic [15:0] exp_mask);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            cond_e = 4'(i);
            #1;
            m[i] = cond_ex_e;
        end
        check(tag, 32'(m), 32'(exp_mask));
    endtask

    task automatic check_squash(input string tag, input logic [15:0] exp);
`ifdef SQUASH_CNT_EN
        check(tag, 32'(squash_cnt), 32'(exp));
`else
        if (exp == 16'hFFFF) $display("unreachable squash tag %s", tag);
`endif
    endtask

    initial begin
        clr_inputs();
        reset = 1'b0;
        #5 reset = 1'b1;
        step(); step();
        check("rst_flags", 32'(flags_q), 32'h0);
        check("rst_result", alu_result_m, 32'h0);
        check("rst_ctl", 32'({reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m}), 32'h0);
        reset = 1'b0;
        step();

        // SUB 10-10 sets Z and C under AL
        cond_e = 4'hE; flag_write_e = 2'b11; alu_flags_e = 4'b0110;
        reg_write_e = 1'b1; rd_e = 4'd5; alu_result_e = 32'd0;
        step();
        check("v1_flags", 32'(flags_q), 32'h6);
        check("v1_rw", 32'(reg_write_m), 32'h1);
        check("v1_rd", 32'(rd_m), 32'h5);
        sweep("sweep_0110", 16'hE6A5);

        clr_inputs(); cond_e = 4'h0; reg_write_e = 1'b1;
        #1 check("v2_cond_eq", 32'(cond_ex_e), 32'h1);
        step();
        check("v2_rw_eq", 32'(reg_write_m), 32'h1);

        cond_e = 4'h1; reg_write_e = 1'b1; rd_e = 4'd9;
        #1 check("v3_cond_ne", 32'(cond_ex_e), 32'h0);
        step();
        check("v3_rw_ne", 32'(reg_write_m), 32'h0);
        check("v3_rd_ne", 32'(rd_m), 32'h9);
        check_squash("v3_sq", 16'd1);

        clr_inputs(); flag_write_e = 2'b11; alu_flags_e = 4'b0000;
        step();
        check("v4_flags", 32'(flags_q), 32'h0);
        flag_write_e = 2'b10; alu_flags_e = 4'b1011;
        step();
        check("v5_partial_nz", 32'(flags_q), 32'h8);
        sweep("sweep_1000", 16'hEA9A);

        clr_inputs(); cond_e = 4'hB; pc_src_e = 1'b1;
        step();
        check("v6_lt_pc", 32'(pc_src_m), 32'h1);

        cond_e = 4'hA; pc_src_e = 1'b1; flag_write_e = 2'b11; alu_flags_e = 4'b0110;
        step();
        check("v7_ge_pc", 32'(pc_src_m), 32'h0);
        check("v7_flags_hold", 32'(flags_q), 32'h8);
        check_squash("v7_sq", 16'd2);

        clr_inputs(); reg_write_e = 1'b1; mem_write_e = 1'b1; mem_to_reg_e = 1'b1;
        alu_result_e = 32'h1234; write_data_e = 32'hAAAA; rd_e = 4'd7;
        step();
        check("v8_ctl", 32'({reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m}), 32'hE);

        stall_e = 1'b1; flush_e = 1'b1; pc_src_e = 1'b1; flag_write_e = 2'b11;
        alu_flags_e = 4'b0110; alu_result_e = 32'hFFFF; write_data_e = 32'h5555; rd_e = 4'd9;
        step();
        check("v9_stall_ctl", 32'({reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m}), 32'hE);
        check("v9_stall_res", alu_result_m, 32'h1234);
        check("v9_stall_wd", write_data_m, 32'hAAAA);
        check("v9_stall_rd", 32'(rd_m), 32'h7);
        check("v9_stall_flags", 32'(flags_q), 32'h8);

        stall_e = 1'b0;
        step();
        check("v10_flush_ctl", 32'({reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m}), 32'h0);
        check("v10_flush_flags", 32'(flags_q), 32'h8);
        check_squash("v10_sq", 16'd2);

        // MUL 7*5 forwarded to MEM unchanged
        clr_inputs(); alu_result_e = 32'd35; rd_e = 4'd3; mem_to_reg_e = 1'b1; write_data_e = 32'hDEAD;
        step();
        check("v11_res", alu_result_m, 32'd35);
        check("v11_rd", 32'(rd_m), 32'h3);
        check("v11_m2r", 32'(mem_to_reg_m), 32'h1);
        check("v11_wd", write_data_m, 32'hDEAD);

        clr_inputs(); cond_e = 4'h0; mem_to_reg_e = 1'b1; mem_write_e = 1'b1;
        step();
        check("v12_mw_squash", 32'(mem_write_m), 32'h0);
        check("v12_m2r_ungated", 32'(mem_to_reg_m), 32'h1);
        check_squash("v12_sq", 16'd3);

        clr_inputs(); flag_write_e = 2'b01; alu_flags_e = 4'b0111; reg_write_e = 1'b1; rd_e = 4'd4;
        step();
        check("v13_partial_cv", 32'(flags_q), 32'hB);
        sweep("sweep_1011", 16'hD556);

        // Asynchronous reset mid-cycle with live state
        clr_inputs();
        #10 reset = 1'b1;
        #1;
        check("arst_flags", 32'(flags_q), 32'h0);
        check("arst_ctl", 32'({reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m}), 32'h0);
        check("arst_rd", 32'(rd_m), 32'h0);
        check("arst_res", alu_result_m, 32'h0);
        check_squash("arst_sq", 16'd0);
        step();
        reset = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_cond_stage.md
Name: ex_mem_cond_stage

Overview:
- Sits directly downstream of the SuperALU, at the EX/MEM boundary of the pipelined processor.
- Holds the architectural NZCV flags register and evaluates the 4-bit condition field of the instruction in EX against the stored flags.
- Squashes side effects of failed-condition instructions, then registers the ALU result and control into the MEM stage.
- Handles stall and flush from the hazard unit.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_W, 4, width of destination register index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall_e  in  1  hold EX/MEM register and flags.
- flush_e  in  1  insert bubble into MEM.
- cond_e  in  4  condition field of instruction in EX.
- flag_write_e  in  2  bit1 enables N,Z update; bit0 enables C,V update.
- alu_flags_e  in  4  SuperALU flags {N,Z,C,V}.
- alu_result_e  in  DATA_W  SuperALU result.
- write_data_e  in  DATA_W  store data.
- rd_e  in  REG_W  destination register.
- reg_write_e, mem_write_e, mem_to_reg_e, pc_src_e  in  1 each  raw EX control.
- cond_ex_e  out  1  combinational condition-pass for current EX instruction.
- flags_q  out  4  architectural {N,Z,C,V}.
- alu_result_m, write_data_m  out  DATA_W  registered.
- rd_m  out  REG_W  registered.
- reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m  out  1 each  registered, condition-gated.

Behaviour:
- Reset, asynchronous: flags_q = 0; all *_m outputs = 0. Takes effect mid-operation regardless of stall/flush.
- cond_ex_e is combinational from cond_e and flags_q, using the ARM encoding:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F treated as always (1).
- Gated controls: ctl_g = ctl_e & cond_ex_e for reg_write, mem_write, pc_src. mem_to_reg passes ungated.
- Priority each rising edge: reset > stall_e > flush_e > normal.
  - stall_e=1: all *_m and flags_q hold, including when flush_e=1 in the same cycle.
  - flush_e=1, stall_e=0: reg_write_m, mem_write_m, mem_to_reg_m, pc_src_m = 0; data/rd fields load as normal (don't-care); flags_q hold.
  - Normal: all *_m load gated values; latency exactly 1 cycle.
- Flag update, normal cycle only, and only if cond_ex_e=1:
  - flag_write_e[1] → N,Z from alu_flags_e[3:2].
  - flag_write_e[0] → C,V from alu_flags_e[1:0].
  - Bits not enabled hold.
- Back-to-back: an instruction's cond evaluates against flags_q written by the immediately preceding instruction at the previous edge (no bypass of alu_flags_e).
- A failed-condition instruction still occupies a MEM slot: rd/result are registered, but its write and branch controls are 0.

Optional Feature:
- Macro SQUASH_CNT_EN.
- Defined: adds output squash_cnt (16 bits).
  - Increments by 1 on each normal (non-stall, non-flush) edge where cond_ex_e=0 and any of reg_write_e, mem_write_e, pc_src_e is 1.
  - Saturates at 16'hFFFF.
  - Reset to 0.
  - Holds on stall and flush.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: assert reset mid-cycle with *_m nonzero → all outputs 0 immediately, before next clk edge; flags_q=0.
- Flag set then EQ: cycle1 SUB 10-10, alu_flags_e=4'b0110, flag_write_e=2'b11, cond=E → flags_q=0110. Cycle2 cond=0 (EQ), reg_write_e=1 → reg_write_m=1. Cycle3 cond=1 (NE) → reg_write_m=0, squash_cnt=1 if enabled.
- Partial flag write: flags_q=0000, flag_write_e=2'b10, alu_flags_e=4'b1011 → flags_q=1000.
- Signed compare: flags_q N=1,V=0 → LT passes, GE fails. pc_src_e=1 with cond=B → pc_src_m=1; with cond=A → pc_src_m=0.
- Stall/flush: stall_e=1 with flush_e=1 and new inputs → *_m and flags_q unchanged. Next cycle flush_e=1 alone → all controls_m=0 and flags_q unchanged despite flag_write_e=11.
- Pass-through: cond=E, alu_result_e=32'd35 (MUL 7*5), rd_e=4'd3, mem_to_reg_e=1 → next edge alu_result_m=35, rd_m=3, mem_to_reg_m=1.
